// File: rtl/mem_access_master.sv
// Initiator for the shared instruction/data memory port: arbitrates fetch and load/store requests.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_access_master #(
   parameter int unsigned RAM_SIZE_BIT = 8,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic             if_ack,
   output logic [31:0]      if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_ack,
   output logic [31:0]      d_rdata,
   output logic             err,
   output logic [31:0]      Address,
   output logic [31:0]      Write_data,
   output logic             MemRead,
   output logic             MemWrite,
   input  logic [31:0]      Mem_data,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_next;

   logic        any_req;
   logic        sel_data;
   logic        sel_we;
   logic        sel_legal;
   logic [31:0] sel_addr;

   logic        we_q;
   logic        src_d_q;
   logic        err_q;

`ifdef MEM_ARB_RR_EN
   logic        last_fetch_q;
`endif

   // Winner selection and legality of the winner's address.
   always_comb begin
      any_req  = d_req | if_req;
`ifdef MEM_ARB_RR_EN
      sel_data = d_req & (~if_req | last_fetch_q);
`else
      sel_data = d_req;
`endif
      sel_addr  = sel_data ? d_addr : if_addr;
      sel_we    = sel_data & d_we;
      sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr[31:RAM_SIZE_BIT+2] == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      if_ack     = 1'b0;
      d_ack      = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = sel_legal ? ACCESS : DONE;
            end
         end
         ACCESS: begin
            MemRead    = ~we_q;
            MemWrite   = we_q;
            state_next = DONE;
         end
         DONE: begin
            if_ack     = ~src_d_q;
            d_ack      = src_d_q;
            err        = err_q;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, memory-side address/data, read-data capture and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q       <= 1'b0;
         src_d_q    <= 1'b0;
         err_q      <= 1'b0;
         Address    <= '0;
         Write_data <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         rd_count   <= '0;
         wr_count   <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            we_q    <= sel_we;
            src_d_q <= sel_data;
            err_q   <= ~sel_legal;
            if (sel_legal) begin
               Address <= sel_addr;
               if (sel_we) begin
                  Write_data <= d_wdata;
               end
            end
         end
         if (state == ACCESS) begin
            if (we_q) begin
               if (wr_count != '1) begin
                  wr_count <= wr_count + CNT_W'(1);
               end
            end else begin
               if (src_d_q) begin
                  d_rdata <= Mem_data;
               end else begin
                  if_rdata <= Mem_data;
               end
               if (rd_count != '1) begin
                  rd_count <= rd_count + CNT_W'(1);
               end
            end
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   // Resets to "fetch won last" so data wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_fetch_q <= 1'b1;
      end else if (state == IDLE && any_req) begin
         last_fetch_q <= ~sel_data;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: a transaction-level model fills a per-cycle schedule of expected
// outputs, and one negedge process compares the DUT against it.
module tb_mem_access_master;

   localparam int RSB   = 8;
   localparam int CW    = 16;
   localparam int DEPTH = 1 << RSB;
   localparam int NCYC  = 512;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [31:0]   if_addr = '0;
   logic          if_ack;
   logic [31:0]   if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [31:0]   d_addr = '0;
   logic [31:0]   d_wdata = '0;
   logic          d_ack;
   logic [31:0]   d_rdata;
   logic          err;
   logic [31:0]   Address;
   logic [31:0]   Write_data;
   logic          MemRead;
   logic          MemWrite;
   logic [31:0]   Mem_data;
   logic [CW-1:0] rd_count;
   logic [CW-1:0] wr_count;

   mem_access_master #(
      .RAM_SIZE_BIT(RSB),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .err       (err),
      .Address   (Address),
      .Write_data(Write_data),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Mem_data  (Mem_data),
      .rd_count  (rd_count),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   // Memory the DUT talks to: combinational read, write on the clock edge.
   logic [31:0] mem [DEPTH];
   assign Mem_data = mem[Address[RSB+1:2]];
   always @(posedge clk) if (MemWrite) mem[Address[RSB+1:2]] <= Write_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Expected outputs per cycle (cycle = posedges seen so far).
   bit        s_rd [NCYC];
   bit        s_wr [NCYC];
   bit        s_ifack [NCYC];
   bit        s_dack [NCYC];
   bit        s_err [NCYC];
   bit [31:0] s_addr [NCYC];
   bit [31:0] s_wdata [NCYC];
   bit [31:0] s_ifrd [NCYC];
   bit [31:0] s_drd [NCYC];
   int        s_rdc [NCYC];
   int        s_wrc [NCYC];

   bit [31:0] ref_mem [DEPTH];
   int        m_rdc = 0;
   int        m_wrc = 0;
   bit        last_fetch = 1'b1;

   function automatic bit [31:0] init_word(input int i);
      return (i == 1) ? 32'h0000_1026 : ((32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5);
   endfunction

   // One granted transaction whose request is sampled at edge k; returns its ack cycle.
   function automatic void model_txn(input bit pd, input bit we, input logic [31:0] addr,
                                     input logic [31:0] wd, input int k, output int ack_c);
      bit legal;
      int idx;
      legal      = (addr % 4 == 0) && (addr < 4 * DEPTH);
      last_fetch = ~pd;
      if (!legal) begin
         ack_c    = k;
         s_err[k] = 1'b1;
      end else begin
         ack_c = k + 1;
         idx   = int'(addr / 4);
         for (int c = k; c < NCYC; c++) begin
            s_addr[c] = addr;
            if (we) s_wdata[c] = wd;
         end
         if (we) begin
            s_wr[k]      = 1'b1;
            ref_mem[idx] = wd;
            if (m_wrc < (1 << CW) - 1) m_wrc++;
            for (int c = k + 1; c < NCYC; c++) s_wrc[c] = m_wrc;
         end else begin
            s_rd[k] = 1'b1;
            if (m_rdc < (1 << CW) - 1) m_rdc++;
            for (int c = k + 1; c < NCYC; c++) begin
               s_rdc[c] = m_rdc;
               if (pd) s_drd[c] = ref_mem[idx];
               else    s_ifrd[c] = ref_mem[idx];
            end
         end
      end
      if (pd) s_dack[ack_c] = 1'b1;
      else    s_ifack[ack_c] = 1'b1;
   endfunction

   function automatic void model_reset(input int from);
      for (int c = from; c < NCYC; c++) begin
         s_rd[c] = 0; s_wr[c] = 0; s_ifack[c] = 0; s_dack[c] = 0; s_err[c] = 0;
         s_addr[c] = 0; s_wdata[c] = 0; s_ifrd[c] = 0; s_drd[c] = 0; s_rdc[c] = 0; s_wrc[c] = 0;
      end
      m_rdc      = 0;
      m_wrc      = 0;
      last_fetch = 1'b1;
   endfunction

   always @(negedge clk) begin
      if (!reset && cyc < NCYC) begin
         chk("rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
         chk("MemRead",    32'(MemRead),  32'(s_rd[cyc]));
         chk("MemWrite",   32'(MemWrite), 32'(s_wr[cyc]));
         chk("Address",    Address,       s_addr[cyc]);
         chk("Write_data", Write_data,    s_wdata[cyc]);
         chk("if_ack",     32'(if_ack),   32'(s_ifack[cyc]));
         chk("d_ack",      32'(d_ack),    32'(s_dack[cyc]));
         chk("err",        32'(err),      32'(s_err[cyc]));
         chk("if_rdata",   if_rdata,      s_ifrd[cyc]);
         chk("d_rdata",    d_rdata,       s_drd[cyc]);
         chk("rd_count",   32'(rd_count), 32'(s_rdc[cyc]));
         chk("wr_count",   32'(wr_count), 32'(s_wrc[cyc]));
      end
   end

   // Single request on one port, released the cycle its ack is expected.
   task automatic go(input bit pd, input bit we, input logic [31:0] addr, input logic [31:0] wd);
      int ack_c;
      @(negedge clk);
      if (pd) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      model_txn(pd, we, addr, wd, cyc + 1, ack_c);
      while (cyc < ack_c) @(negedge clk);
      if (pd) d_req = 1'b0;
      else    if_req = 1'b0;
      @(negedge clk);
   endtask

   // Both ports raise loads together and each keeps req high until all its loads are served.
   task automatic run_pair(input int nd, input int nf, output int order);
      int id = 0;
      int jf = 0;
      int k;
      int ack_c;
      bit pd;
      logic [31:0] addr;
      order = 0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = '0;
      if_req = 1'b1; if_addr = 32'h20;
      k = cyc + 1;
      while (id < nd || jf < nf) begin
         if (id < nd && jf < nf) begin
`ifdef MEM_ARB_RR_EN
            pd = last_fetch;
`else
            pd = 1'b1;
`endif
         end else begin
            pd = (id < nd);
         end
         order = (order << 1) | int'(pd);
         addr  = pd ? 32'h10 + 32'(4 * id) : 32'h20 + 32'(4 * jf);
         model_txn(pd, 1'b0, addr, 32'd0, k, ack_c);
         while (cyc < ack_c) @(negedge clk);
         if (pd) begin
            id++;
            if (id < nd) d_addr = 32'h10 + 32'(4 * id);
            else         d_req = 1'b0;
         end else begin
            jf++;
            if (jf < nf) if_addr = 32'h20 + 32'(4 * jf);
            else         if_req = 1'b0;
         end
         k = ack_c + 2;
      end
      @(negedge clk);
   endtask

   initial begin
      int k;
      int order;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = init_word(i);
         ref_mem[i] = init_word(i);
      end

      repeat (2) @(negedge clk);
      chk("reset_MemRead",  32'(MemRead),  32'd0);
      chk("reset_MemWrite", 32'(MemWrite), 32'd0);
      chk("reset_Address",  Address,       32'd0);
      chk("reset_acks",     32'({if_ack, d_ack, err}), 32'd0);
      chk("reset_rdata",    if_rdata | d_rdata, 32'd0);
      chk("reset_counts",   32'({rd_count, wr_count}), 32'd0);
      #1 reset = 1'b0;

      go(1'b0, 1'b0, 32'h0000_0004, 32'd0);
      chk("fetch_rdata", if_rdata, 32'h0000_1026);
      chk("fetch_rdcnt", 32'(rd_count), 32'd1);

      go(1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF);
      chk("store_wrcnt", 32'(wr_count), 32'd1);
      go(1'b1, 1'b0, 32'h0000_0080, 32'd0);
      chk("load_rdata", d_rdata, 32'hDEAD_BEEF);

      go(1'b1, 1'b0, 32'h0000_0082, 32'd0);
      chk("misalign_rdata", d_rdata, 32'hDEAD_BEEF);
      chk("misalign_rdcnt", 32'(rd_count), 32'd2);

      go(1'b0, 1'b0, 32'h0000_0400, 32'd0);
      chk("range_rdata", if_rdata, 32'h0000_1026);

      run_pair(2, 2, order);
`ifdef MEM_ARB_RR_EN
      chk("grant_order", 32'(order), 32'b1010);
`else
      chk("grant_order", 32'(order), 32'b1100);
`endif

      // Reset asserted in the middle of a store's ACCESS cycle.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
      k = cyc + 1;
      for (int c = k; c < NCYC; c++) begin
         s_addr[c]  = 32'h40;
         s_wdata[c] = 32'h1234_5678;
      end
      s_wr[k] = 1'b1;
      while (cyc < k) @(negedge clk);
      #1 reset = 1'b1;
      d_req = 1'b0;
      #1;
      chk("rst_MemWrite",   32'(MemWrite), 32'd0);
      chk("rst_Address",    Address,       32'd0);
      chk("rst_Write_data", Write_data,    32'd0);
      chk("rst_d_ack",      32'(d_ack),    32'd0);
      chk("rst_rdata",      if_rdata | d_rdata, 32'd0);
      chk("rst_counts",     32'({rd_count, wr_count}), 32'd0);
      model_reset(cyc + 1);
      @(negedge clk);
      #1 reset = 1'b0;

      go(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
      go(1'b1, 1'b0, 32'h0000_0040, 32'd0);
      chk("reissue_rdata", d_rdata, 32'h1234_5678);
      chk("reissue_wrcnt", 32'(wr_count), 32'd1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator side of the unified instruction/data memory port in the multi-cycle CPU.
- Accepts requests from an instruction-fetch port and a data (load/store) port using a req/ack handshake.
- Arbitrates between the two and drives the memory's Address/Write_data/MemRead/MemWrite lines, one transaction at a time.
- Captures Mem_data into a register and returns it with a one-cycle ack; flags misaligned or out-of-range accesses instead of issuing them.

Parameters:
- RAM_SIZE_BIT, 8, log2 of memory depth in words; legal byte addresses are 0 .. 4*2^RAM_SIZE_BIT-1.
- CNT_W, 16, width of the saturating read/write access counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- if_req  input  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  input  32  fetch byte address.
- if_ack  output  1  one-cycle pulse: fetch complete, if_rdata/err valid.
- if_rdata  output  32  fetched instruction word.
- d_req  input  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_ack  output  1  one-cycle pulse: data access complete.
- d_rdata  output  32  load result.
- err  output  1  valid with the ack pulse: access rejected (misaligned or out of range).
- Address  output  32  memory address.
- Write_data  output  32  memory write data.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; memory writes on the clk edge.
- Mem_data  input  32  combinational memory read data.
- rd_count  output  CNT_W  saturating count of completed reads.
- wr_count  output  CNT_W  saturating count of completed writes.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: FSM = IDLE; every output = 0 (Address, Write_data, MemRead, MemWrite, acks, rdata, err, counters).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On each edge, sample the request lines. If any req is high, select a winner and latch its address, data, we and source.
  - If the address is illegal, go directly to DONE with err=1. Illegal means addr[1:0]!=0, or addr[31:RAM_SIZE_BIT+2]!=0.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - Address = latched address.
  - Read: MemRead=1, MemWrite=0; Mem_data is captured into the winner's rdata register at the closing edge.
  - Write: MemWrite=1, MemRead=0, Write_data = latched data.
  - Next state: DONE.
- DONE (one cycle):
  - The winner's ack = 1; err reflects the latched error.
  - MemRead = MemWrite = 0; Address and Write_data hold their last value.
  - Next state: IDLE.
- Latency: req seen at edge N, ACCESS during cycle N+1, ack during cycle N+2. A rejected access acks during cycle N+1.
- Requesters drop req on the edge that samples ack. Req still high in IDLE after its ack is a new transaction.
- MemRead and MemWrite are never high simultaneously and are high only in ACCESS.
- Arbitration default: d_req has fixed priority over if_req. The loser waits with req held; it is not acknowledged.
- rdata registers persist until overwritten by the next read of the same port. Writes and errors do not modify rdata.
- Counters:
  - rd_count increments at the ACCESS closing edge of a legal read; wr_count does the same for a legal write.
  - Both saturate at all-ones. Rejected accesses do not count.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No ack is issued and a partially started write is not retried; the requester re-issues.
- Requests that change while pending are a protocol violation. Behaviour follows the latched values.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a last-winner flag is kept. When both reqs are high in IDLE, the port that did not win the previous granted transaction wins. The flag resets to "fetch won last", so data wins the first tie.
- Undefined: fixed data-over-fetch priority; the flag logic is absent.

Test Plan:
- Fetch, no contention: after reset, if_req=1, if_addr=0x00000004, memory word 1 = 0x00001026 -> MemRead=1 with Address=0x4 one cycle after sampling; if_ack pulses one cycle later with if_rdata=0x00001026, err=0, rd_count=1.
- Store then load: d_req, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF -> MemWrite=1 for exactly one cycle, d_ack, wr_count=1. Then a load from 0x80 -> d_rdata=0xDEADBEEF.
- Misaligned address: d_addr=0x82 -> no MemRead/MemWrite ever asserted; d_ack with err=1 in the cycle after sampling; counters unchanged, d_rdata unchanged.
- Out of range: if_addr=0x400 with RAM_SIZE_BIT=8 -> if_ack with err=1, no memory strobe.
- Contention: if_req and d_req both high from the same edge -> without the macro, data is served first, then fetch; with MEM_ARB_RR_EN and repeated ties, grants alternate data, fetch, data, fetch.
- Reset mid-ACCESS: assert reset during a write's ACCESS cycle -> all outputs 0 asynchronously, no d_ack, FSM in IDLE. After release, a re-issued request completes normally.
